// File: rtl/phase_sequencer.sv
// Phase sequencer: tags each sample of a packet with a running phase {phase, q, i} for the rotator.
// Latency: one cycle from s handshake to m_valid; one sample per cycle while m_ready is high.
// Backpressure: single output register; s_ready drops while the held word is stalled by m_ready.
module phase_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [2*WIDTH-1:0]   cfg_freq,
    input  logic [2*WIDTH-1:0]   cfg_phase,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [2*WIDTH-1:0]   s_data,
    input  logic                 s_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [4*WIDTH-1:0]   m_data,
    output logic                 m_last,
    output logic [15:0]          count,
    output logic                 busy
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]           state_q,   state_d;
    logic [2*WIDTH-1:0]   acc_q,     acc_d;
    logic [2*WIDTH-1:0]   inc_q,     inc_d;
    logic [15:0]          count_q,   count_d;
    logic                 m_valid_q, m_valid_d;
    logic [4*WIDTH-1:0]   m_data_q,  m_data_d;
    logic                 m_last_q,  m_last_d;

    logic cfg_fire;
    logic s_fire;
    logic m_fire;

    // Handshake readiness depends only on state and the output register, never on the valids.
    always_comb begin
        cfg_ready = !reset && (state_q == ST_IDLE);
        s_ready   = !reset && (state_q == ST_RUN) && (!m_valid_q || m_ready);
        cfg_fire  = cfg_valid && cfg_ready;
        s_fire    = s_valid && s_ready;
        m_fire    = m_valid_q && m_ready;
    end

    // Next-state logic: configuration load in IDLE, phase tagging and accumulation in RUN.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        inc_d     = inc_q;
        count_d   = count_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;

        // Draining the held word; a same-cycle accept below re-asserts valid.
        if (m_fire) begin
            m_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                // The previous packet's last word may still be held; it is left untouched.
                if (cfg_fire) begin
                    inc_d   = cfg_freq;
                    acc_d   = cfg_phase;
                    count_d = 16'd0;
                    state_d = ST_RUN;
                end
            end
            default: begin
                if (s_fire) begin
                    m_data_d  = {acc_q, s_data};
                    m_last_d  = s_last;
                    m_valid_d = 1'b1;
                    // Phase wraps modulo 2^(2*WIDTH) by natural truncation.
                    acc_d     = acc_q + inc_q;
                    if (count_q != 16'hFFFF) begin
                        count_d = count_q + 16'd1;
                    end
                    if (s_last) begin
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
    end

    // State registers with synchronous reset; an in-flight word is discarded on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            inc_q     <= '0;
            count_q   <= 16'd0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            inc_q     <= inc_d;
            count_q   <= count_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;
    assign count   = count_q;
    assign busy    = (state_q == ST_RUN) || m_valid_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_phase_sequencer;

    logic        clk;
    logic        reset;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_freq;
    logic [31:0] cfg_phase;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_last;
    logic        m_valid;
    logic        m_ready;
    logic [63:0] m_data;
    logic        m_last;
    logic [15:0] count;
    logic        busy;

    int checks;
    int failures;
    logic [63:0] got[$];

    phase_sequencer #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_freq(cfg_freq), .cfg_phase(cfg_phase),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .count(count), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, cv;
        logic [31:0] f, p;
        logic        sv;
        logic [31:0] sd;
        logic        sl, mr;
        logic        e_crdy, e_srdy, e_mv;
        logic [63:0] e_md;
        logic        e_ml;
        logic [15:0] e_cnt;
        logic        e_busy;
    } vec_t;

    function automatic vec_t mk(input logic rst, cv, input logic [31:0] f, p, input logic sv,
                                input logic [31:0] sd, input logic sl, mr,
                                input logic crdy, srdy, mv, input logic [63:0] md,
                                input logic ml, input logic [15:0] cnt, input logic bsy);
        vec_t v;
        v.rst = rst; v.cv = cv; v.f = f; v.p = p; v.sv = sv; v.sd = sd; v.sl = sl; v.mr = mr;
        v.e_crdy = crdy; v.e_srdy = srdy; v.e_mv = mv; v.e_md = md; v.e_ml = ml;
        v.e_cnt = cnt; v.e_busy = bsy;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, settle, and log any output handshake.
    task automatic drive(input logic r, cv, input logic [31:0] f, p, input logic sv,
                         input logic [31:0] sd, input logic sl, mr);
        @(negedge clk);
        reset = r; cfg_valid = cv; cfg_freq = f; cfg_phase = p;
        s_valid = sv; s_data = sd; s_last = sl; m_ready = mr;
        #1;
        if (!r && m_valid && m_ready) got.push_back(m_data);
    endtask

    task automatic idle(input logic mr);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, mr);
    endtask

    task automatic cfg(input logic [31:0] f, p, input logic mr);
        drive(1'b0, 1'b1, f, p, 1'b0, 32'h0, 1'b0, mr);
    endtask

    task automatic smp(input logic [31:0] sd, input logic sl, mr);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, sd, sl, mr);
    endtask

    task automatic chk_got(input string nm, input int idx, input logic [63:0] exp);
        if (idx < got.size()) chk(nm, got[idx], exp);
        else chk(nm, 64'hDEAD_DEAD_DEAD_DEAD, exp);
    endtask

    localparam logic [31:0] SD64 = 32'h0000_0064;
    localparam logic [31:0] SDN  = 32'hFFFB_0007;

    vec_t tbl[12];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1; cfg_valid = 1'b0; cfg_freq = '0; cfg_phase = '0;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;

        // Ramp packet followed by wrap packet, cycle by cycle.
        tbl[0]  = mk(1,0,32'h0,32'h0,0,32'h0,0,1,          0,0,0,64'h0,0,16'd0,0);
        tbl[1]  = mk(0,1,32'h1000_0000,32'h0,0,32'h0,0,1,  1,0,0,64'h0,0,16'd0,0);
        tbl[2]  = mk(0,0,32'h0,32'h0,1,SD64,0,1,           0,1,0,64'h0,0,16'd0,1);
        tbl[3]  = mk(0,0,32'h0,32'h0,1,SD64,0,1,           0,1,1,{32'h0000_0000,SD64},0,16'd1,1);
        tbl[4]  = mk(0,0,32'h0,32'h0,1,SD64,0,1,           0,1,1,{32'h1000_0000,SD64},0,16'd2,1);
        tbl[5]  = mk(0,0,32'h0,32'h0,1,SD64,1,1,           0,1,1,{32'h2000_0000,SD64},0,16'd3,1);
        tbl[6]  = mk(0,1,32'h2000_0000,32'hF000_0000,0,32'h0,0,1,
                                                           1,0,1,{32'h3000_0000,SD64},1,16'd4,1);
        tbl[7]  = mk(0,0,32'h0,32'h0,1,SDN,0,1,            0,1,0,64'h0,0,16'd0,1);
        tbl[8]  = mk(0,0,32'h0,32'h0,1,SDN,0,1,            0,1,1,{32'hF000_0000,SDN},0,16'd1,1);
        tbl[9]  = mk(0,0,32'h0,32'h0,1,SDN,1,1,            0,1,1,{32'h1000_0000,SDN},0,16'd2,1);
        tbl[10] = mk(0,0,32'h0,32'h0,0,32'h0,0,1,          1,0,1,{32'h3000_0000,SDN},1,16'd3,1);
        tbl[11] = mk(0,0,32'h0,32'h0,0,32'h0,0,1,          1,0,0,64'h0,0,16'd3,0);

        drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].rst, tbl[i].cv, tbl[i].f, tbl[i].p, tbl[i].sv, tbl[i].sd, tbl[i].sl, tbl[i].mr);
            chk($sformatf("row%0d cfg_ready", i), cfg_ready, tbl[i].e_crdy);
            chk($sformatf("row%0d s_ready", i), s_ready, tbl[i].e_srdy);
            chk($sformatf("row%0d m_valid", i), m_valid, tbl[i].e_mv);
            chk($sformatf("row%0d count", i), count, tbl[i].e_cnt);
            chk($sformatf("row%0d busy", i), busy, tbl[i].e_busy);
            if (tbl[i].e_mv) begin
                chk($sformatf("row%0d m_data", i), m_data, tbl[i].e_md);
                chk($sformatf("row%0d m_last", i), m_last, tbl[i].e_ml);
            end
        end

        // Backpressure: three stalled cycles, held word stable, no loss or duplication.
        got.delete();
        cfg(32'h0000_0100, 32'h0000_1000, 1'b1);
        smp(32'h0001_0001, 1'b0, 1'b1);
        chk("bp first accept s_ready", s_ready, 1'b1);
        smp(32'h0002_0002, 1'b0, 1'b0);
        chk("bp stall1 s_ready", s_ready, 1'b0);
        chk("bp stall1 m_data", m_data, {32'h0000_1000, 32'h0001_0001});
        smp(32'h0002_0002, 1'b0, 1'b0);
        chk("bp stall2 m_data", m_data, {32'h0000_1000, 32'h0001_0001});
        smp(32'h0002_0002, 1'b0, 1'b0);
        chk("bp stall3 s_ready", s_ready, 1'b0);
        chk("bp stall3 m_valid", m_valid, 1'b1);
        smp(32'h0002_0002, 1'b0, 1'b1);
        chk("bp resume s_ready", s_ready, 1'b1);
        smp(32'h0003_0003, 1'b1, 1'b1);
        idle(1'b1);
        chk("bp last m_last", m_last, 1'b1);
        idle(1'b1);
        chk("bp drained m_valid", m_valid, 1'b0);
        chk("bp word count", got.size(), 3);
        chk_got("bp word0", 0, {32'h0000_1000, 32'h0001_0001});
        chk_got("bp word1", 1, {32'h0000_1100, 32'h0002_0002});
        chk_got("bp word2", 2, {32'h0000_1200, 32'h0003_0003});

        // Negative increment; samples offered in IDLE are refused; cfg pulse in RUN ignored.
        got.delete();
        smp(32'h0000_0AAA, 1'b0, 1'b1);
        chk("gate idle s_ready", s_ready, 1'b0);
        smp(32'h0000_0AAA, 1'b0, 1'b1);
        chk("gate idle m_valid", m_valid, 1'b0);
        chk("gate idle count", count, 16'd3);
        drive(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0000_0AAA, 1'b0, 1'b1);
        chk("neg cfg s_ready", s_ready, 1'b0);
        drive(1'b0, 1'b1, 32'h0000_0055, 32'h0000_0077, 1'b1, 32'h0000_0AAA, 1'b0, 1'b1);
        chk("neg run cfg_ready", cfg_ready, 1'b0);
        chk("neg run count", count, 16'd0);
        smp(32'h0000_0BBB, 1'b0, 1'b1);
        smp(32'h0000_0CCC, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("neg word count", got.size(), 3);
        chk_got("neg word0", 0, {32'h0000_0000, 32'h0000_0AAA});
        chk_got("neg word1", 1, {32'hFFFF_FFFF, 32'h0000_0BBB});
        chk_got("neg word2", 2, {32'hFFFF_FFFE, 32'h0000_0CCC});

        // Reset after two of five samples, then restart from the new configuration.
        cfg(32'h0000_0010, 32'h0000_0500, 1'b1);
        smp(32'h0000_0001, 1'b0, 1'b1);
        smp(32'h0000_0002, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0003, 1'b0, 1'b1);
        chk("rst held cfg_ready", cfg_ready, 1'b0);
        chk("rst held s_ready", s_ready, 1'b0);
        idle(1'b1);
        chk("rst after m_valid", m_valid, 1'b0);
        chk("rst after count", count, 16'd0);
        chk("rst after cfg_ready", cfg_ready, 1'b1);
        chk("rst after busy", busy, 1'b0);
        got.delete();
        cfg(32'h0000_0003, 32'h0000_0ABC, 1'b1);
        smp(32'h0000_0009, 1'b1, 1'b1);
        idle(1'b1);
        chk("rst restart words", got.size(), 1);
        chk_got("rst restart word0", 0, {32'h0000_0ABC, 32'h0000_0009});

        // Back-to-back: configure B while A's single last word is stalled.
        idle(1'b1);
        got.delete();
        cfg(32'h0000_0001, 32'h0000_0040, 1'b0);
        smp(32'h0000_00AA, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 32'h0000_0002, 32'h0000_0900, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("b2b cfg_ready", cfg_ready, 1'b1);
        chk("b2b held A data", m_data, {32'h0000_0040, 32'h0000_00AA});
        chk("b2b held A busy", busy, 1'b1);
        smp(32'h0000_00B0, 1'b0, 1'b0);
        chk("b2b A unchanged", m_data, {32'h0000_0040, 32'h0000_00AA});
        chk("b2b A m_last", m_last, 1'b1);
        chk("b2b stall s_ready", s_ready, 1'b0);
        chk("b2b stall busy", busy, 1'b1);
        smp(32'h0000_00B0, 1'b0, 1'b1);
        chk("b2b drain busy", busy, 1'b1);
        smp(32'h0000_00B1, 1'b1, 1'b1);
        chk("b2b B busy", busy, 1'b1);
        idle(1'b1);
        chk("b2b tail busy", busy, 1'b1);
        idle(1'b1);
        chk("b2b done busy", busy, 1'b0);
        chk("b2b word count", got.size(), 3);
        chk_got("b2b wordA", 0, {32'h0000_0040, 32'h0000_00AA});
        chk_got("b2b wordB0", 1, {32'h0000_0900, 32'h0000_00B0});
        chk_got("b2b wordB1", 2, {32'h0000_0902, 32'h0000_00B1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Phase sequencer that drives the CORDIC rotator input stream. It accepts one configuration (phase increment, initial phase) per packet, then tags each incoming complex sample with a running phase. It emits `{phase, q, i}` words in exactly the rotator's `s_data` layout, so the rotator performs per-packet frequency-offset correction or mixing. It sits directly upstream of the rotator; a packet ends on `s_last`, after which a new configuration is required.

## Interface
- `WIDTH`, default 16: sample component width. Phase width is 2*`WIDTH`.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `cfg_valid`  in  1  configuration offered.
- `cfg_ready`  out  1  configuration accepted when both `cfg_valid` and `cfg_ready` are high.
- `cfg_freq`  in  2*WIDTH  signed phase increment per sample. Full scale 2^(2*WIDTH) = 2π.
- `cfg_phase`  in  2*WIDTH  phase applied to the first sample of the packet.
- `s_valid`  in  1  sample offered.
- `s_ready`  out  1  sample accepted when both `s_valid` and `s_ready` are high.
- `s_data`  in  2*WIDTH  `{q, i}`, each signed `WIDTH`, with `i` in the LSBs.
- `s_last`  in  1  marks the final sample of the packet.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  downstream (rotator) ready.
- `m_data`  out  4*WIDTH  `{phase[2*WIDTH-1:0], q, i}`.
- `m_last`  out  1  `s_last` of the sample currently in `m_data`, for a sideband delay line.
- `count`  out  16  samples accepted in the current packet. Saturates at 0xFFFF.
- `busy`  out  1  asserted when the state is RUN or `m_valid` is high.

## Operation
- FSM with two states: IDLE and RUN. Reset state is IDLE.
- IDLE:
  - `cfg_ready` = 1, `s_ready` = 0.
  - On a cfg handshake: `inc` <= `cfg_freq`, `acc` <= `cfg_phase`, `count` <= 0, then go to RUN.
- RUN:
  - `cfg_ready` = 0. `cfg_valid` is ignored; it is not latched.
  - `s_ready` = `!m_valid || m_ready`.
  - On an s handshake:
    - `m_data` <= `{acc, s_data}`, `m_last` <= `s_last`, `m_valid` <= 1.
    - `acc` <= `acc + inc`, modulo 2^(2*WIDTH). Wrap-around is silent.
    - `count` increments, saturating.
  - On an s handshake with `s_last` = 1: go to IDLE.
- Phase of sample n (0-based) = `cfg_phase + n*cfg_freq` mod 2^(2*WIDTH). This holds regardless of gaps or stalls.
- Output register behaviour:
  - `m_valid` clears on an m handshake unless a new s handshake occurs in the same cycle.
  - `m_data` and `m_last` hold stable while `m_valid && !m_ready`.
- A cfg handshake in IDLE may occur while `m_valid` still holds the previous packet's last word. That word is unaffected and drains normally.
- `cfg_ready` and `s_ready` are combinational from the state and `m_valid`/`m_ready`. Neither depends on `cfg_valid` or `s_valid`.
- Reset mid-packet:
  - State goes to IDLE.
  - `m_valid` <= 0, `m_last` <= 0, `count` <= 0, `acc` <= 0, `inc` <= 0.
  - Any in-flight sample is dropped.

## Timing
- Latency: an s handshake in cycle t gives `m_valid` = 1 in cycle t+1.
- Throughput: one sample per cycle while `m_ready` is held high.
- First sample accept: the cfg handshake in cycle t puts the FSM in RUN in t+1; the earliest s handshake is in t+1.
- Packet end: the `s_last` handshake in cycle t gives `cfg_ready` = 1 in t+1. The minimum bubble between packets is one cycle.
- Reset values:
  - `m_valid` = 0, `m_last` = 0, `m_data` = 0, `count` = 0, `busy` = 0.
  - `cfg_ready` = 0 and `s_ready` = 0 while `reset` is high.
  - `cfg_ready` = 1 in the first cycle after `reset` deasserts.
- Handshake rules, both directions:
  - Once `m_valid` is asserted, it stays asserted with stable data until `m_ready`.
  - Upstream holds `s_valid`/`s_data` stable until accepted.

## Test plan
- **Ramp.** `WIDTH`=16, cfg `freq`=0x1000_0000, `phase`=0. Send 4 samples with i=100, q=0, last on the 4th. Required `m_data` phases: 0x00000000, 0x10000000, 0x20000000, 0x30000000. `m_last` is set only on the 4th word. `count`=4. `cfg_ready`=1 the cycle after the 4th accept.
- **Wrap.** `phase`=0xF000_0000, `freq`=0x2000_0000, 3 samples. Required phases: 0xF0000000, 0x10000000, 0x30000000.
- **Backpressure.** In RUN, hold `m_ready`=0 for 3 cycles with `s_valid`=1. Required: `s_ready`=0 after the first accept, `m_data` stable, no sample lost or duplicated. Phases stay contiguous after `m_ready` returns.
- **Negative increment and IDLE gating.** `freq`=0xFFFF_FFFF (−1), `phase`=0. Required phases: 0, 0xFFFFFFFF, 0xFFFFFFFE. Samples offered in IDLE before configuration are not accepted. `cfg_valid` pulsed in RUN changes nothing.
- **Reset mid-packet.** Assert `reset` for 1 cycle after 2 of 5 samples. Required: `m_valid`=0 and `count`=0 next cycle, and FSM in IDLE. A new cfg then restarts at its own `cfg_phase`.
- **Back-to-back packets.** Packet A is 1 sample with `last`. Issue cfg B while A's word is still stalled (`m_ready`=0). Required: A's word is unchanged. B's first phase equals cfg B `phase`. `busy` stays 1 throughout.
